// File: rtl/llr_fetch_unit.sv
// llr_fetch_unit: reads one frame of LLR words from a synchronous memory,
// using the LDPC address generator as the address counter.
// Ports:
//   clk, reset           - rising-edge clock, async active-high reset
//   start                - frame request, only honoured while idle
//   ag_addr/ag_en/ag_clr - address generator: address in, enable and clear out
//   mem_rd_en/mem_addr   - LLR memory read strobe and address
//   mem_rdata            - read data, returned one cycle after mem_rd_en
//   out_*                - 2-deep buffered valid/ready output stream
//   busy/done            - frame in progress / one-cycle end-of-frame pulse
module llr_fetch_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int LLR_WIDTH  = 6,
  parameter int FRAME_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ag_addr,
  output logic                  ag_en,
  output logic                  ag_clr,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [LLR_WIDTH-1:0]  mem_rdata,
  output logic [LLR_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so a full 2^DATA_WIDTH frame is countable.
  localparam int CW = DATA_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FETCH, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        issued_q, issued_d;
  logic [CW-1:0]        popped_q, popped_d;
  logic                 inflight_q, inflight_d;
  logic                 ag_clr_q, ag_clr_d;
  logic                 done_q, done_d;
  logic [LLR_WIDTH-1:0] fifo_q [2];
  logic [LLR_WIDTH-1:0] fifo_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;

  logic                 issue;
  logic                 pop;
  logic [2:0]           occ;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    ag_clr_d   = 1'b0;
    done_d     = 1'b0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    issue      = 1'b0;
    pop        = (cnt_q != 2'd0) && out_ready;
    // Words held or on their way, after this cycle's pop.
    occ        = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};

    unique case (state_q)
      IDLE: begin
        // done_q high means the last frame just ended; a start in
        // that same cycle is dropped.
        if (start && !done_q) begin
          state_d  = CLEAR;
          ag_clr_d = 1'b1;
        end
      end
      CLEAR: begin
        issued_d = '0;
        popped_d = '0;
        state_d  = FETCH;
      end
      FETCH: begin
        issue = (occ < 3'd2);
        if (issue) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      popped_d = popped_q + 1'b1;
      rd_ptr_d = ~rd_ptr_q;
      if (popped_q == LAST && state_q == DRAIN) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    inflight_d = issue;
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      ag_clr_q   <= 1'b0;
      done_q     <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      ag_clr_q   <= ag_clr_d;
      done_q     <= done_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ag_en     = issue;
  assign mem_rd_en = issue;
  assign mem_addr  = ag_addr;
  assign ag_clr    = ag_clr_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && (popped_q == LAST);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_llr_fetch_unit.sv
// Bench for llr_fetch_unit: three instances (frame lengths 4, 8, 256)
// with an address generator and memory model, word[a] = a + 10.
module tb_llr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [2:0] out_ready;
  logic [2:0] ag_en, ag_clr, mem_rd_en;
  logic [2:0] out_valid, out_last, busy, done;
  logic [7:0] ag_addr [3] = '{8'h33, 8'h5a, 8'hc1};
  logic [7:0] mem_addr [3];
  logic [5:0] mem_rdata [3];
  logic [5:0] out_data [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int fl(input int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : 256;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g
      llr_fetch_unit #(
        .DATA_WIDTH(8),
        .LLR_WIDTH(6),
        .FRAME_LEN((gi == 0) ? 4 : (gi == 1) ? 8 : 256)
      ) dut (
        .clk(clk),
        .reset(reset),
        .start(start[gi]),
        .ag_addr(ag_addr[gi]),
        .ag_en(ag_en[gi]),
        .ag_clr(ag_clr[gi]),
        .mem_rd_en(mem_rd_en[gi]),
        .mem_addr(mem_addr[gi]),
        .mem_rdata(mem_rdata[gi]),
        .out_data(out_data[gi]),
        .out_valid(out_valid[gi]),
        .out_ready(out_ready[gi]),
        .out_last(out_last[gi]),
        .busy(busy[gi]),
        .done(done[gi])
      );
    end
  endgenerate

  // Address generator (clear to 0, count on enable) and synchronous memory.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ag_clr[i]) ag_addr[i] <= 8'd0;
      else if (ag_en[i]) ag_addr[i] <= ag_addr[i] + 8'd1;
      if (mem_rd_en[i]) mem_rdata[i] <= 6'(mem_addr[i] + 8'd10);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame-level model: words go out in order (k+10)%64, reads are
  // addresses 0..FL-1, done follows the FL-th pop.
  int m_iss [3];
  int m_pop [3];
  bit m_busy [3];
  bit m_done [3];
  bit m_clr [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit acc;
      bit lastpop;
      if (reset) begin
        m_iss[i] = 0; m_pop[i] = 0;
        m_busy[i] = 0; m_done[i] = 0; m_clr[i] = 0;
      end
      chk($sformatf("busy%0d", i), busy[i], m_busy[i]);
      chk($sformatf("done%0d", i), done[i], m_done[i]);
      chk($sformatf("ag_clr%0d", i), ag_clr[i], m_clr[i]);
      chk($sformatf("en_eq_rd%0d", i), ag_en[i], mem_rd_en[i]);
      if (ag_en[i]) begin
        chk($sformatf("rd_addr%0d", i), mem_addr[i], m_iss[i]);
        chk($sformatf("rd_in_frame%0d", i),
            (m_iss[i] < fl(i)) && m_busy[i] && !m_clr[i], 1);
      end
      if (out_valid[i]) begin
        chk($sformatf("data%0d", i), out_data[i], (m_pop[i] + 10) % 64);
        chk($sformatf("valid_in_frame%0d", i), m_busy[i], 1);
      end
      chk($sformatf("last%0d", i), out_last[i],
          out_valid[i] && (m_pop[i] == fl(i) - 1));
      chk($sformatf("outstanding%0d", i), (m_iss[i] - m_pop[i]) <= 2, 1);
      if (!reset) begin
        acc = !m_busy[i] && start[i] && !m_done[i];
        lastpop = 0;
        if (ag_en[i]) m_iss[i]++;
        if (out_valid[i] && out_ready[i]) begin
          m_pop[i]++;
          if (m_pop[i] == fl(i)) begin
            lastpop = 1;
            chk($sformatf("reads_per_frame%0d", i), m_iss[i], fl(i));
          end
        end
        if (acc) begin
          m_busy[i] = 1; m_iss[i] = 0; m_pop[i] = 0;
        end
        if (lastpop) m_busy[i] = 0;
        m_clr[i] = acc;
        m_done[i] = lastpop;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  // Entered at edge+1; samples each cycle until done is seen.
  task automatic run(input int i, input bit toggle, input int budget,
                     output int pops, output int reads, output int lasts,
                     output int first_data, output int last_data,
                     output int span, output bit ok);
    int fp;
    int lp;
    pops = 0; reads = 0; lasts = 0; first_data = -1; last_data = -1;
    fp = -1; lp = -1; ok = 0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (ag_en[i]) reads++;
      if (out_valid[i] && out_ready[i]) begin
        if (pops == 0) begin first_data = out_data[i]; fp = c; end
        lp = c;
        pops++;
        if (out_last[i]) begin lasts++; last_data = out_data[i]; end
      end
      if (done[i]) begin ok = 1; break; end
      @(posedge clk);
      #1;
      if (toggle) out_ready[i] = ~out_ready[i];
    end
    span = lp - fp;
  endtask

  int pops, reads, lasts, fd, ld, span, n, clrs, dn;
  bit ok;
  bit v [8];
  bit l [8];
  bit c [8];
  bit b [8];
  bit d [8];
  int dat [8];

  initial begin
    reset = 1'b1;
    start = '0;
    out_ready = '0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ctrl%0d", i),
          {ag_en[i], ag_clr[i], mem_rd_en[i], out_valid[i],
           out_last[i], busy[i], done[i]}, 0);
      chk($sformatf("rst_data%0d", i), out_data[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();

    // Basic frame, FRAME_LEN=4.
    out_ready[0] = 1'b1;
    pulse_start(0);
    for (int k = 0; k < 8; k++) begin
      v[k] = out_valid[0]; l[k] = out_last[0]; c[k] = ag_clr[0];
      b[k] = busy[0]; d[k] = done[0]; dat[k] = out_data[0];
      step();
    end
    chk("t1_clr_k0", c[0], 1);
    chk("t1_clr_k1", c[1], 0);
    chk("t1_valid_k2", v[2], 0);
    for (int k = 3; k < 7; k++) begin
      chk($sformatf("t1_valid_k%0d", k), v[k], 1);
      chk($sformatf("t1_data_k%0d", k), dat[k], 7 + k);
    end
    chk("t1_last_k5", l[5], 0);
    chk("t1_last_k6", l[6], 1);
    chk("t1_done_k6", d[6], 0);
    chk("t1_done_k7", d[7], 1);
    chk("t1_busy_k6", b[6], 1);
    chk("t1_busy_k7", b[7], 0);
    chk("t1_valid_k7", v[7], 0);
    repeat (3) step();

    // Backpressure, FRAME_LEN=8.
    out_ready[1] = 1'b0;
    pulse_start(1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      n += ag_en[1];
      step();
    end
    chk("t2_stall_issues", n, 2);
    chk("t2_stall_en", ag_en[1], 0);
    chk("t2_stall_valid", out_valid[1], 1);
    out_ready[1] = 1'b1;
    run(1, 0, 40, pops, reads, lasts, fd, ld, span, ok);
    chk("t2_done", ok, 1);
    chk("t2_pops", pops, 8);
    chk("t2_reads_after", reads, 6);
    chk("t2_first", fd, 10);
    chk("t2_last", ld, 17);
    chk("t2_span", span, 7);
    repeat (3) step();

    // Toggling out_ready, FRAME_LEN=8.
    out_ready[1] = 1'b1;
    pulse_start(1);
    run(1, 1, 80, pops, reads, lasts, fd, ld, span, ok);
    chk("t3_done", ok, 1);
    chk("t3_reads", reads, 8);
    chk("t3_pops", pops, 8);
    chk("t3_lasts", lasts, 1);
    chk("t3_last_word", ld, 17);
    out_ready[1] = 1'b1;
    repeat (3) step();

    // start held through FETCH and the done cycle.
    out_ready[0] = 1'b1;
    start[0] = 1'b1;
    clrs = 0; reads = 0; ok = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      clrs += ag_clr[0];
      reads += ag_en[0];
      if (done[0]) begin ok = 1; break; end
    end
    chk("t4_done", ok, 1);
    step();
    start[0] = 1'b0;
    chk("t4_clr_after_done", ag_clr[0], 0);
    chk("t4_busy_after_done", busy[0], 0);
    chk("t4_clrs", clrs, 1);
    chk("t4_reads", reads, 4);
    step();
    pulse_start(0);
    run(0, 0, 20, pops, reads, lasts, fd, ld, span, ok);
    chk("t4b_done", ok, 1);
    chk("t4b_first", fd, 10);
    chk("t4b_pops", pops, 4);
    repeat (3) step();

    // Asynchronous reset mid-FETCH.
    out_ready[1] = 1'b1;
    pulse_start(1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      n += ag_en[1];
      if (n == 3) break;
      step();
    end
    chk("t5_third_issue", n, 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_ctrl",
        {ag_en[1], ag_clr[1], mem_rd_en[1], out_valid[1],
         out_last[1], busy[1], done[1]}, 0);
    chk("t5_rst_data", out_data[1], 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      dn += done[1];
    end
    chk("t5_no_done", dn, 0);
    pulse_start(1);
    run(1, 0, 40, pops, reads, lasts, fd, ld, span, ok);
    chk("t5_done", ok, 1);
    chk("t5_first", fd, 10);
    chk("t5_pops", pops, 8);
    repeat (3) step();

    // Full frame, FRAME_LEN=256.
    out_ready[2] = 1'b1;
    pulse_start(2);
    run(2, 0, 400, pops, reads, lasts, fd, ld, span, ok);
    chk("t6_done", ok, 1);
    chk("t6_pops", pops, 256);
    chk("t6_reads", reads, 256);
    chk("t6_lasts", lasts, 1);
    chk("t6_last_word", ld, 9);
    dn = 0; n = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      dn += done[2];
      n += ag_en[2];
    end
    chk("t6_extra_done", dn, 0);
    chk("t6_extra_reads", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
